// File: rtl/mux_sel_scanner.sv
// Select-line scanner for a 4:1 mux: walks enabled channels in ascending order,
// holds each select for DWELL cycles and captures mux_out into a per-channel bit.
module mux_sel_scanner #(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] mask,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       sample_q, sample_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       higher;
    logic             dwell_end;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        if (v[0]) return 2'd0;
        if (v[1]) return 2'd1;
        if (v[2]) return 2'd2;
        return 2'd3;
    endfunction

    // Enabled channels strictly above the current select.
    assign higher    = mask_q & ~((4'b0010 << sel_q) - 4'd1);
    assign dwell_end = (cnt_q == CNT_W'(DWELL - 1));

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    sample_d = 4'b0000;
                    if (mask != 4'b0000) begin
                        mask_d  = mask;
                        sel_d   = lowest(mask);
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = StScan;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StScan: begin
                cnt_d = cnt_q + 1'b1;
                if (dwell_end) begin
                    sample_d[sel_q] = mux_out;
                    cnt_d           = '0;
                    if (higher != 4'b0000) begin
                        sel_d = lowest(higher);
                    end else begin
                        sel_d   = 2'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            sel_q    <= 2'd0;
            cnt_q    <= '0;
            mask_q   <= 4'b0000;
            sample_q <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign s1     = sel_q[1];
    assign s0     = sel_q[0];
    assign busy   = busy_q;
    assign done   = done_q;
    assign sample = sample_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Scoreboard bench for mux_sel_scanner: one instance with DWELL=2, one with DWELL=1,
// each driving its own model of the downstream 4:1 mux.
module tb_mux_sel_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] mask;
    logic [3:0] din;

    logic       s0_a, s1_a, busy_a, done_a, mux_a;
    logic       s0_b, s1_b, busy_b, done_b, mux_b;
    logic [3:0] sample_a, sample_b;

    int checks = 0;
    int errors = 0;
    int cur    = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic [3:0] smp;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign mux_a = din[{s1_a, s0_a}];
    assign mux_b = din[{s1_b, s0_b}];

    mux_sel_scanner #(.DWELL(2), .CNT_W(4)) u_dut_a (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mask   (mask),
        .mux_out(mux_a),
        .s0     (s0_a),
        .s1     (s1_a),
        .busy   (busy_a),
        .done   (done_a),
        .sample (sample_a)
    );

    mux_sel_scanner #(.DWELL(1), .CNT_W(4)) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mask   (mask),
        .mux_out(mux_b),
        .s0     (s0_b),
        .s1     (s1_b),
        .busy   (busy_b),
        .done   (done_b),
        .sample (sample_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", tag, cur, $time, got, exp);
        end
    endtask

    function automatic exp_t observe();
        if (cur == 1) return {s1_b, s0_b, busy_b, done_b, sample_b};
        return {s1_a, s0_a, busy_a, done_a, sample_a};
    endfunction

    task automatic check_state(input exp_t e);
        exp_t o;
        o = observe();
        check("sel", 32'(o.sel), 32'(e.sel));
        check("busy", 32'(o.busy), 32'(e.busy));
        check("done", 32'(o.done), 32'(e.done));
        check("sample", 32'(o.smp), 32'(e.smp));
    endtask

    // Expected state after each edge from acceptance up to and including the done cycle.
    task automatic push_scan(input logic [3:0] m, input int dw, input logic [3:0] d,
                             output logic [3:0] fin);
        logic [3:0] acc;
        acc = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                for (int j = 0; j < dw; j++) exp_q.push_back({2'(k), 1'b1, 1'b0, acc});
                acc[k] = d[k];
            end
        end
        exp_q.push_back({2'd0, 1'b0, 1'b1, acc});
        fin = acc;
    endtask

    task automatic run(input int which, input logic [3:0] m, input int dw, input logic [3:0] d,
                       input bit noise, input bit chain);
        logic [3:0] fin;
        exp_t       e;
        bit         chained;
        cur = which;
        din = d;
        push_scan(m, dw, d, fin);
        if (chain) push_scan(m, dw, d, fin);
        exp_q.push_back({2'd0, 1'b0, 1'b0, fin});
        chained = 1'b0;
        @(negedge clk);
        start = 1'b1;
        mask  = m;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_state(e);
            start = 1'b0;
            mask  = noise ? ~m : m;
            if (noise && e.busy) start = 1'b1;
            if (chain && e.done && !chained) begin
                start   = 1'b1;
                chained = 1'b1;
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mask  = 4'b0000;
        din   = 4'b0000;
        repeat (3) @(negedge clk);
        cur = 0;
        check_state({2'd0, 1'b0, 1'b0, 4'b0000});
        cur = 1;
        check_state({2'd0, 1'b0, 1'b0, 4'b0000});
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run(0, 4'b1111, 2, 4'b0101, 1'b0, 1'b0);
        run(0, 4'b1010, 2, 4'b0101, 1'b0, 1'b0);
        run(0, 4'b1010, 2, 4'b0111, 1'b0, 1'b0);
        run(0, 4'b0000, 2, 4'b0101, 1'b0, 1'b0);
        run(0, 4'b1111, 2, 4'b0101, 1'b1, 1'b0);

        // Reset lands during the third scan cycle; channel 0 has already been sampled.
        cur = 0;
        din = 4'b0101;
        @(negedge clk);
        start = 1'b1;
        mask  = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_sample", 32'(sample_a), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check_state({2'd0, 1'b0, 1'b0, 4'b0000});
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run(0, 4'b1111, 2, 4'b0101, 1'b0, 1'b0);

        run(1, 4'b1111, 1, 4'b0110, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
